// File: rtl/branch_pkg.sv
// Shared definitions for branch resolution: branch op codes, FSM state
// encoding and the BHT reset value. The branch comparator and the decoder
// use the same op codes.
package branch_pkg;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_JUMP = 2'b10;

    // Counter value for "weakly not taken"
    localparam logic [1:0] BHT_RESET_VAL = 2'b01;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } branch_state_e;

    // Next value of a 2-bit saturating counter for a taken / not-taken outcome
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2^IDX_BITS two-bit saturating counters with one
// combinational read port and one synchronous update port.
module branch_bht
    import branch_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0] ctr [ENTRIES];

    // Read returns the stored value, so a same-cycle write is visible only
    // from the following cycle.
    assign rd_ctr = ctr[rd_idx];

    // Counter array: reset to weakly-not-taken, saturating train on update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= BHT_RESET_VAL;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer: compares the EX outcome with the fetch-time
// prediction, issues a registered redirect on a mismatch, holds a fixed-length
// flush of the younger stages, counts mispredicts and trains the BHT.
//
// Redirect handshake: redirect_valid is a single-cycle pulse with no ready;
// fetch must load redirect_pc in the cycle redirect_valid is high. There is
// no back-pressure, so the pulse is never repeated or extended.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_IDX_BITS = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic [1:0]      ex_branch_op,
    input  logic            ex_do_branch,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            busy,
    output logic [15:0]     mispredict_count
);

    branch_state_e state, state_next;
    logic [2:0]    flush_cnt, flush_cnt_next;

    logic            is_branch;
    logic            resolve;
    logic            mispredict;
    logic            train;
    logic [XLEN-1:0] correct_pc;
    logic [1:0]      rd_ctr;

    assign is_branch  = (ex_branch_op == BR_COND) || (ex_branch_op == BR_JUMP);
    // Wrong-path instructions arriving during a flush never resolve
    assign resolve    = ex_valid && !ex_stall && is_branch && (state == ST_IDLE);
    assign mispredict = resolve && (ex_do_branch != ex_pred_taken);
    // Only conditional branches carry useful direction history
    assign train      = resolve && (ex_branch_op == BR_COND);
    assign correct_pc = ex_do_branch ? ex_target : (ex_pc + XLEN'(4));

    assign if_pred_taken = rd_ctr[1];
    assign flush         = (state == ST_FLUSH);
    assign busy          = (state != ST_IDLE);

    branch_bht #(
        .IDX_BITS (BHT_IDX_BITS)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[BHT_IDX_BITS+1:2]),
        .rd_ctr   (rd_ctr),
        .wr_en    (train),
        .wr_idx   (ex_pc[BHT_IDX_BITS+1:2]),
        .wr_taken (ex_do_branch)
    );

    // FSM state and flush counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flush_cnt <= 3'd0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // Next state: a mispredict enters FLUSH, which lasts FLUSH_CYCLES cycles
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            ST_IDLE: begin
                if (mispredict) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = 3'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == 3'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    flush_cnt_next = flush_cnt - 3'd1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                flush_cnt_next = 3'd0;
            end
        endcase
    end

    // Redirect pulse, held redirect target and saturating mispredict counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            mispredict_count <= 16'd0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) begin
                redirect_pc <= correct_pc;
                if (mispredict_count != 16'hFFFF) begin
                    mispredict_count <= mispredict_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a table of per-cycle vectors with
// hand-computed expected outputs, then a hand-written mid-flush reset sequence.
module tb_branch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic [1:0]  ex_branch_op;
    logic        ex_do_branch;
    logic        ex_pred_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        busy;
    logic [15:0] mispredict_count;

    int tests_run = 0;
    int fail_count = 0;

    branch_ctrl #(
        .XLEN         (32),
        .BHT_IDX_BITS (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_branch_op     (ex_branch_op),
        .ex_do_branch     (ex_do_branch),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .busy             (busy),
        .mispredict_count (mispredict_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] if_pc;
        logic        valid;
        logic        stall;
        logic [1:0]  op;
        logic        do_br;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_flush;
        logic        e_busy;
        logic [15:0] e_cnt;
        logic        e_pt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [31:0] ipc, input logic v, input logic s, input logic [1:0] op,
        input logic d, input logic p, input logic [31:0] pc, input logic [31:0] tgt,
        input logic rv, input logic [31:0] rpc, input logic fl, input logic bz,
        input logic [15:0] cnt, input logic pt);
        vec_t r;
        r.if_pc = ipc; r.valid = v; r.stall = s; r.op = op;
        r.do_br = d; r.pred = p; r.pc = pc; r.tgt = tgt;
        r.e_rv = rv; r.e_rpc = rpc; r.e_flush = fl; r.e_busy = bz;
        r.e_cnt = cnt; r.e_pt = pt;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_pc         = v.if_pc;
        ex_valid      = v.valid;
        ex_stall      = v.stall;
        ex_branch_op  = v.op;
        ex_do_branch  = v.do_br;
        ex_pred_taken = v.pred;
        ex_pc         = v.pc;
        ex_target     = v.tgt;
    endtask

    task automatic check_outputs(input int idx, input logic rv, input logic [31:0] rpc,
                                 input logic fl, input logic bz, input logic [15:0] cnt,
                                 input logic pt);
        check("redirect_valid", idx, 32'(redirect_valid), 32'(rv));
        check("redirect_pc", idx, redirect_pc, rpc);
        check("flush", idx, 32'(flush), 32'(fl));
        check("busy", idx, 32'(busy), 32'(bz));
        check("mispredict_count", idx, 32'(mispredict_count), 32'(cnt));
        check("if_pred_taken", idx, 32'(if_pred_taken), 32'(pt));
    endtask

    vec_t idle_v;

    initial begin
        // Expected state after each clock edge, BHT idx(0x100)=0, idx(0x104)=1,
        // idx(0xFFFFFFFC)=15; all entries start at 01.
        // Mispredict taken -> redirect 0x80, flush 2 cycles, BHT[0] 01->10
        vecs.push_back(mk(32'h100, 1, 0, 2'b01, 1, 0, 32'h100, 32'h80,  1, 32'h80, 1, 1, 16'd1, 1));
        vecs.push_back(mk(32'h100, 0, 0, 2'b00, 0, 0, 32'h0,   32'h0,   0, 32'h80, 1, 1, 16'd1, 1));
        vecs.push_back(mk(32'h100, 0, 0, 2'b00, 0, 0, 32'h0,   32'h0,   0, 32'h80, 0, 0, 16'd1, 1));
        // Correct taken resolves: 10->11, then saturate at 11
        vecs.push_back(mk(32'h100, 1, 0, 2'b01, 1, 1, 32'h100, 32'h80,  0, 32'h80, 0, 0, 16'd1, 1));
        vecs.push_back(mk(32'h100, 1, 0, 2'b01, 1, 1, 32'h100, 32'h80,  0, 32'h80, 0, 0, 16'd1, 1));
        // Correct not-taken resolves: 11->10->01->00, then hold at 00
        vecs.push_back(mk(32'h100, 1, 0, 2'b01, 0, 0, 32'h100, 32'h80,  0, 32'h80, 0, 0, 16'd1, 1));
        vecs.push_back(mk(32'h100, 1, 0, 2'b01, 0, 0, 32'h100, 32'h80,  0, 32'h80, 0, 0, 16'd1, 0));
        vecs.push_back(mk(32'h100, 1, 0, 2'b01, 0, 0, 32'h100, 32'h80,  0, 32'h80, 0, 0, 16'd1, 0));
        vecs.push_back(mk(32'h100, 1, 0, 2'b01, 0, 0, 32'h100, 32'h80,  0, 32'h80, 0, 0, 16'd1, 0));
        // Taken from 00 -> 01
        vecs.push_back(mk(32'h100, 1, 0, 2'b01, 1, 1, 32'h100, 32'h80,  0, 32'h80, 0, 0, 16'd1, 0));
        // Mispredicted jump: redirect, but BHT[0] stays 01
        vecs.push_back(mk(32'h100, 1, 0, 2'b10, 1, 0, 32'h100, 32'h200, 1, 32'h200, 1, 1, 16'd2, 0));
        // Wrong-path mispredicting branches during flush are ignored
        vecs.push_back(mk(32'h100, 1, 0, 2'b01, 1, 0, 32'h100, 32'h300, 0, 32'h200, 1, 1, 16'd2, 0));
        vecs.push_back(mk(32'h100, 1, 0, 2'b01, 1, 0, 32'h100, 32'h300, 0, 32'h200, 0, 0, 16'd2, 0));
        // Not-taken mispredict at top of address space: ex_pc+4 wraps to 0
        vecs.push_back(mk(32'hFFFFFFFC, 1, 0, 2'b01, 0, 1, 32'hFFFFFFFC, 32'h40, 1, 32'h0, 1, 1, 16'd3, 0));
        vecs.push_back(mk(32'hFFFFFFFC, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 1, 16'd3, 0));
        vecs.push_back(mk(32'hFFFFFFFC, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 16'd3, 0));
        // Op 11 is not a branch: no redirect, no training
        vecs.push_back(mk(32'h104, 1, 0, 2'b11, 1, 0, 32'h104, 32'h500, 0, 32'h0, 0, 0, 16'd3, 0));
        // Stalled mispredicting branch for 3 cycles, then released
        vecs.push_back(mk(32'h104, 1, 1, 2'b01, 1, 0, 32'h104, 32'h400, 0, 32'h0, 0, 0, 16'd3, 0));
        vecs.push_back(mk(32'h104, 1, 1, 2'b01, 1, 0, 32'h104, 32'h400, 0, 32'h0, 0, 0, 16'd3, 0));
        vecs.push_back(mk(32'h104, 1, 1, 2'b01, 1, 0, 32'h104, 32'h400, 0, 32'h0, 0, 0, 16'd3, 0));
        vecs.push_back(mk(32'h104, 1, 0, 2'b01, 1, 0, 32'h104, 32'h400, 1, 32'h400, 1, 1, 16'd4, 1));

        idle_v = mk(32'h104, 0, 0, 2'b00, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 16'd0, 0);

        // Reset block
        rst_n = 1'b0;
        drive(idle_v);
        if_pc = 32'h100;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_outputs(-1, 0, 32'h0, 0, 0, 16'd0, 0);

        // Vector table: drive on a falling edge, check on the next falling edge
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check_outputs(i, vecs[i].e_rv, vecs[i].e_rpc, vecs[i].e_flush,
                          vecs[i].e_busy, vecs[i].e_cnt, vecs[i].e_pt);
        end

        // Mid-flush reset: now in the first flush cycle, BHT[1]=10
        drive(idle_v);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs(100, 0, 32'h0, 0, 0, 16'd0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // No redirect replayed and no flush after release
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_outputs(101 + k, 0, 32'h0, 0, 0, 16'd0, 0);
        end
        if_pc = 32'h100;
        #1;
        check("if_pred_taken_bht0", 104, 32'(if_pred_taken), 32'd0);
        if_pc = 32'hFFFFFFFC;
        #1;
        check("if_pred_taken_bht15", 105, 32'(if_pred_taken), 32'd0);

        // Reset restores 01, so one taken training must flip BHT[1] to 10
        drive(mk(32'h104, 1, 0, 2'b01, 1, 1, 32'h104, 32'h0, 0, 32'h0, 0, 0, 16'd0, 1));
        @(negedge clk);
        check_outputs(106, 0, 32'h0, 0, 0, 16'd0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
